// File: rtl/jtag_dmi_pkg.sv
// Shared DMI widths, op/resp codes and the arbiter state type used by the
// DMI arbiter slice.
package jtag_dmi_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/jtag_dmi_arbiter_if.sv
// Requester-side and Debug-Module-side DMI signals of the arbiter.
// NUM_REQ must match the arbiter instance it is bound to.
interface jtag_dmi_arbiter_if
  import jtag_dmi_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                     m_req_valid;
  logic [NUM_REQ-1:0]                     m_req_ready;
  logic [NUM_REQ-1:0][DMI_ADDR_WIDTH-1:0] m_addr;
  logic [NUM_REQ-1:0][DMI_DATA_WIDTH-1:0] m_wdata;
  logic [NUM_REQ-1:0][1:0]                m_op;
  logic [NUM_REQ-1:0]                     m_rsp_valid;
  logic [DMI_DATA_WIDTH-1:0]              m_rsp_rdata;
  logic [1:0]                             m_rsp_resp;

  logic [DMI_ADDR_WIDTH-1:0]              dmi_addr;
  logic [DMI_DATA_WIDTH-1:0]              dmi_wdata;
  logic [1:0]                             dmi_op;
  logic                                   dmi_req_valid;
  logic                                   dmi_req_ready;
  logic                                   dmi_rsp_valid;
  logic [DMI_DATA_WIDTH-1:0]              dmi_rdata;
  logic [1:0]                             dmi_resp;

  modport slave (
    input  m_req_valid, m_addr, m_wdata, m_op,
    input  dmi_req_ready, dmi_rsp_valid, dmi_rdata, dmi_resp,
    output m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_resp,
    output dmi_addr, dmi_wdata, dmi_op, dmi_req_valid
  );

  modport master (
    output m_req_valid, m_addr, m_wdata, m_op,
    output dmi_req_ready, dmi_rsp_valid, dmi_rdata, dmi_resp,
    input  m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_resp,
    input  dmi_addr, dmi_wdata, dmi_op, dmi_req_valid
  );

endinterface

// File: rtl/jtag_rr_arbiter.sv
// Combinational round-robin pick: searches upward starting one past i_last.
module jtag_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic               o_any,
  output logic [IW-1:0]      o_gnt_id,
  output logic [NUM_REQ-1:0] o_gnt_oh
);

  logic [IW-1:0] w_idx;

  always_comb begin
    o_any    = 1'b0;
    o_gnt_id = '0;
    o_gnt_oh = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((int'(i_last) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any           = 1'b1;
        o_gnt_id        = w_idx;
        o_gnt_oh[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtag_dmi_arbiter.sv
// Shares one Debug Module DMI port among NUM_REQ requesters, one transaction
// outstanding, with a local FAILED response when the DM hangs in WAIT.
module jtag_dmi_arbiter
  import jtag_dmi_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtag_dmi_arbiter_if.slave    bus,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic [7:0]           timeout_count
);

  // state | meaning: IDLE arbitrate+accept | ISSUE drive DMI request |
  //                  WAIT await DM response or timeout | RESP pulse m_rsp_valid
  localparam int            TW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

  arb_state_e                r_state;
  logic [IW-1:0]             r_grant;
  logic [IW-1:0]             r_last;
  logic [DMI_ADDR_WIDTH-1:0] r_addr;
  logic [DMI_DATA_WIDTH-1:0] r_wdata;
  logic [1:0]                r_op;
  logic                      r_req_valid;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [DMI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_resp;
  logic [TW-1:0]             r_timer;
  logic [7:0]                r_to_cnt;

  logic                      w_any;
  logic [IW-1:0]             w_win;
  logic [NUM_REQ-1:0]        w_win_oh;
  logic [1:0]                w_op;

  jtag_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req    (bus.m_req_valid),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_gnt_id (w_win),
    .o_gnt_oh (w_win_oh)
  );

  assign w_op            = bus.m_op[w_win];
  assign bus.m_req_ready = (r_state == ARB_IDLE) ? w_win_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_last      <= IW'(NUM_REQ - 1);
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op        <= DMI_OP_NOP;
      r_req_valid <= 1'b0;
      r_rsp_valid <= '0;
      r_rdata     <= '0;
      r_resp      <= DMI_RESP_SUCCESS;
      r_timer     <= '0;
      r_to_cnt    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_addr  <= bus.m_addr[w_win];
            r_wdata <= bus.m_wdata[w_win];
            r_op    <= w_op;
            r_grant <= w_win;
            r_last  <= w_win;
            if (w_op == DMI_OP_READ || w_op == DMI_OP_WRITE) begin
              r_req_valid <= 1'b1;
              r_state     <= ARB_ISSUE;
            end else begin
              // NOP completes locally; the reserved op is answered FAILED
              r_rdata     <= '0;
              r_resp      <= (w_op == DMI_OP_NOP) ? DMI_RESP_SUCCESS : DMI_RESP_FAILED;
              r_rsp_valid <= w_win_oh;
              r_state     <= ARB_RESP;
            end
          end
        end
        ARB_ISSUE: begin
          if (bus.dmi_req_ready) begin
            r_req_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.dmi_rsp_valid) begin
            r_rdata     <= bus.dmi_rdata;
            r_resp      <= bus.dmi_resp;
            r_rsp_valid <= NUM_REQ'(1) << r_grant;
            r_state     <= ARB_RESP;
          end else if (TIMEOUT_CYCLES != 0 && r_timer == TO_LIM) begin
            r_rdata     <= '0;
            r_resp      <= DMI_RESP_FAILED;
            r_rsp_valid <= NUM_REQ'(1) << r_grant;
            if (r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
            r_state     <= ARB_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ARB_RESP: begin
          r_rsp_valid <= '0;
          r_state     <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.dmi_addr      = r_addr;
  assign bus.dmi_wdata     = r_wdata;
  assign bus.dmi_op        = r_op;
  assign bus.dmi_req_valid = r_req_valid;
  assign bus.m_rsp_valid   = r_rsp_valid;
  assign bus.m_rsp_rdata   = r_rdata;
  assign bus.m_rsp_resp    = r_resp;
  assign grant_id          = r_grant;
  assign busy              = (r_state != ARB_IDLE);
  assign timeout_count     = r_to_cnt;

endmodule

// File: tb/tb_jtag_dmi_arbiter.sv
// Self-checking bench for jtag_dmi_arbiter: scenario tasks with randomized
// payloads and latencies, checked against a round-robin/timeout reference model.
module tb_jtag_dmi_arbiter;
  import jtag_dmi_pkg::*;

  localparam int NREQ = 2;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] grant_id;
  logic       busy;
  logic [7:0] timeout_count;

  jtag_dmi_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  jtag_dmi_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int m_last;
  int m_to;

  // Winner = requesting port at the smallest forward distance past m_last.
  function automatic int pick(input logic [NREQ-1:0] req);
    int best = -1;
    int bestd = NREQ;
    for (int p = 0; p < NREQ; p++) begin
      int d = (p - m_last - 1 + NREQ) % NREQ;
      if (req[p] && d < bestd) begin
        best = p;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic logic [1:0] rand_resp();
    int r = $urandom_range(0, 2);
    return (r == 0) ? DMI_RESP_SUCCESS : (r == 1) ? DMI_RESP_FAILED : DMI_RESP_BUSY;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.m_req_valid = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_op = '0;
    bus.dmi_req_ready = 1'b0; bus.dmi_rsp_valid = 1'b0; bus.dmi_rdata = '0; bus.dmi_resp = '0;
    rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (bus.dmi_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_dmi_req_valid got %b want 0", bus.dmi_req_valid); end
    n_vec++; if (bus.m_rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_m_rsp_valid got %b want 00", bus.m_rsp_valid); end
    n_vec++; if (bus.m_req_ready !== 2'b00) begin n_err++; $display("FAIL reset_m_req_ready got %b want 00", bus.m_req_ready); end
    n_vec++; if ({busy, grant_id, timeout_count} !== 10'd0) begin n_err++; $display("FAIL reset_status got busy=%b gid=%0d to=%0d want 0", busy, grant_id, timeout_count); end
    n_vec++; if ({bus.dmi_addr, bus.dmi_wdata, bus.dmi_op, bus.m_rsp_rdata, bus.m_rsp_resp} !== '0) begin n_err++; $display("FAIL reset_payload got nonzero payload/rdata"); end
    rst_n = 1'b1;
    m_last = NREQ - 1;
    m_to = 0;
    tick();
  endtask

  task automatic test_single_read();
    int ex;
    bus.m_req_valid = 2'b01; bus.m_addr[0] = 7'h10; bus.m_op[0] = DMI_OP_READ; bus.m_wdata[0] = $urandom;
    #1;
    ex = pick(2'b01);
    n_vec++; if (bus.m_req_ready !== NREQ'(1) << ex) begin n_err++; $display("FAIL read_ready got %b want %b", bus.m_req_ready, NREQ'(1) << ex); end
    tick(); m_last = ex; bus.m_req_valid = '0;
    n_vec++; if ({bus.dmi_req_valid, bus.dmi_addr, bus.dmi_op} !== {1'b1, 7'h10, DMI_OP_READ}) begin n_err++; $display("FAIL read_issue got v=%b a=%h op=%0d want v=1 a=10 op=1", bus.dmi_req_valid, bus.dmi_addr, bus.dmi_op); end
    n_vec++; if ({busy, grant_id} !== {1'b1, 1'(ex)}) begin n_err++; $display("FAIL read_busy got busy=%b gid=%0d want 1/%0d", busy, grant_id, ex); end
    bus.dmi_req_ready = 1'b1; tick(); bus.dmi_req_ready = 1'b0;
    n_vec++; if (bus.dmi_req_valid !== 1'b0) begin n_err++; $display("FAIL read_wait_valid got %b want 0", bus.dmi_req_valid); end
    bus.dmi_rsp_valid = 1'b1; bus.dmi_rdata = 32'hDEADBEEF; bus.dmi_resp = DMI_RESP_SUCCESS;
    tick(); bus.dmi_rsp_valid = 1'b0;
    n_vec++; if ({bus.m_rsp_valid, bus.m_rsp_rdata, bus.m_rsp_resp} !== {2'b01, 32'hDEADBEEF, DMI_RESP_SUCCESS}) begin n_err++; $display("FAIL read_rsp got v=%b d=%h r=%0d want 01/deadbeef/0", bus.m_rsp_valid, bus.m_rsp_rdata, bus.m_rsp_resp); end
    tick();
    n_vec++; if ({bus.m_rsp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL read_done got v=%b busy=%b want 00/0", bus.m_rsp_valid, busy); end
  endtask

  task automatic test_fairness();
    int ex, d, lat;
    logic [DMI_ADDR_WIDTH-1:0] ea;
    logic [DMI_DATA_WIDTH-1:0] ew, er;
    logic [1:0] eo, erc;
    for (int p = 0; p < NREQ; p++) begin
      bus.m_addr[p] = 7'($urandom); bus.m_wdata[p] = $urandom;
      bus.m_op[p] = $urandom_range(0, 1) ? DMI_OP_READ : DMI_OP_WRITE;
    end
    bus.m_req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      ex = pick(2'b11);
      ea = bus.m_addr[ex]; ew = bus.m_wdata[ex]; eo = bus.m_op[ex];
      n_vec++; if (bus.m_req_ready !== NREQ'(1) << ex) begin n_err++; $display("FAIL fair_grant t=%0d got %b want %b", t, bus.m_req_ready, NREQ'(1) << ex); end
      tick(); m_last = ex;
      bus.m_addr[ex] = 7'($urandom); bus.m_wdata[ex] = $urandom;
      bus.m_op[ex] = $urandom_range(0, 1) ? DMI_OP_READ : DMI_OP_WRITE;
      d = $urandom_range(0, 3);
      for (int c = 0; c <= d; c++) begin
        if (c == d) bus.dmi_req_ready = 1'b1;
        #1;
        n_vec++; if ({bus.dmi_req_valid, bus.dmi_addr, bus.dmi_wdata, bus.dmi_op, bus.m_req_ready} !== {1'b1, ea, ew, eo, 2'b00}) begin n_err++; $display("FAIL fair_issue t=%0d got v=%b a=%h w=%h op=%0d rdy=%b want 1/%h/%h/%0d/00", t, bus.dmi_req_valid, bus.dmi_addr, bus.dmi_wdata, bus.dmi_op, bus.m_req_ready, ea, ew, eo); end
        tick();
      end
      bus.dmi_req_ready = 1'b0;
      lat = $urandom_range(0, 3);
      for (int c = 0; c < lat; c++) begin
        n_vec++; if ({bus.m_rsp_valid, bus.m_req_ready} !== 4'b0000) begin n_err++; $display("FAIL fair_wait t=%0d got v=%b rdy=%b want 00/00", t, bus.m_rsp_valid, bus.m_req_ready); end
        tick();
      end
      er = $urandom; erc = rand_resp();
      bus.dmi_rsp_valid = 1'b1; bus.dmi_rdata = er; bus.dmi_resp = erc;
      tick(); bus.dmi_rsp_valid = 1'b0;
      n_vec++; if ({bus.m_rsp_valid, bus.m_rsp_rdata, bus.m_rsp_resp, grant_id} !== {NREQ'(1) << ex, er, erc, 1'(ex)}) begin n_err++; $display("FAIL fair_rsp t=%0d got v=%b d=%h r=%0d gid=%0d want %b/%h/%0d/%0d", t, bus.m_rsp_valid, bus.m_rsp_rdata, bus.m_rsp_resp, grant_id, NREQ'(1) << ex, er, erc, ex); end
      tick();
    end
    bus.m_req_valid = '0;
  endtask

  task automatic test_backpressure();
    int ex;
    logic [DMI_ADDR_WIDTH-1:0] ea;
    logic [DMI_DATA_WIDTH-1:0] ew;
    bus.m_req_valid = 2'b10; bus.m_op[1] = DMI_OP_WRITE;
    ea = 7'($urandom); ew = $urandom;
    bus.m_addr[1] = ea; bus.m_wdata[1] = ew;
    #1;
    ex = pick(2'b10);
    n_vec++; if (bus.m_req_ready !== NREQ'(1) << ex) begin n_err++; $display("FAIL bp_grant got %b want %b", bus.m_req_ready, NREQ'(1) << ex); end
    tick(); m_last = ex;
    bus.m_req_valid = 2'b01; bus.m_op[0] = DMI_OP_READ;
    for (int c = 0; c < 7; c++) begin
      n_vec++; if ({bus.dmi_req_valid, bus.dmi_addr, bus.dmi_wdata, bus.dmi_op, bus.m_req_ready} !== {1'b1, ea, ew, DMI_OP_WRITE, 2'b00}) begin n_err++; $display("FAIL bp_hold c=%0d got v=%b a=%h w=%h op=%0d rdy=%b", c, bus.dmi_req_valid, bus.dmi_addr, bus.dmi_wdata, bus.dmi_op, bus.m_req_ready); end
      tick();
    end
    bus.dmi_req_ready = 1'b1; tick(); bus.dmi_req_ready = 1'b0;
    bus.dmi_rsp_valid = 1'b1; bus.dmi_rdata = $urandom; bus.dmi_resp = DMI_RESP_SUCCESS;
    tick(); bus.dmi_rsp_valid = 1'b0;
    n_vec++; if (bus.m_rsp_valid !== NREQ'(1) << ex) begin n_err++; $display("FAIL bp_rsp got %b want %b", bus.m_rsp_valid, NREQ'(1) << ex); end
    tick();
    ex = pick(2'b01);
    n_vec++; if (bus.m_req_ready !== NREQ'(1) << ex) begin n_err++; $display("FAIL bp_next_grant got %b want %b", bus.m_req_ready, NREQ'(1) << ex); end
    bus.m_req_valid = '0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bus.m_req_valid = 2'b01; bus.m_op[0] = DMI_OP_READ; bus.m_addr[0] = 7'($urandom);
    tick(); m_last = 0; bus.m_req_valid = '0;
    bus.dmi_req_ready = 1'b1; tick(); bus.dmi_req_ready = 1'b0;
    n = 0;
    while (bus.m_rsp_valid === 2'b00 && n < 40) begin
      tick(); n++;
    end
    n_vec++; if (n !== TO + 1) begin n_err++; $display("FAIL to_latency got %0d cycles want %0d", n, TO + 1); end
    m_to = (m_to < 255) ? m_to + 1 : 255;
    n_vec++; if ({bus.m_rsp_valid, bus.m_rsp_rdata, bus.m_rsp_resp} !== {2'b01, 32'h0, DMI_RESP_FAILED}) begin n_err++; $display("FAIL to_rsp got v=%b d=%h r=%0d want 01/0/2", bus.m_rsp_valid, bus.m_rsp_rdata, bus.m_rsp_resp); end
    n_vec++; if (timeout_count !== 8'(m_to)) begin n_err++; $display("FAIL to_count got %0d want %0d", timeout_count, m_to); end
    tick();
    bus.dmi_rsp_valid = 1'b1; bus.dmi_rdata = $urandom; bus.dmi_resp = DMI_RESP_SUCCESS;
    tick(); bus.dmi_rsp_valid = 1'b0;
    n_vec++; if ({bus.m_rsp_valid, busy, timeout_count} !== {2'b00, 1'b0, 8'(m_to)}) begin n_err++; $display("FAIL to_late got v=%b busy=%b cnt=%0d want 00/0/%0d", bus.m_rsp_valid, busy, timeout_count, m_to); end
    tick();
    n_vec++; if ({bus.m_rsp_valid, bus.m_rsp_rdata} !== {2'b00, 32'h0}) begin n_err++; $display("FAIL to_late2 got v=%b d=%h want 00/0", bus.m_rsp_valid, bus.m_rsp_rdata); end
  endtask

  task automatic test_nop_reserved();
    int ex;
    bus.m_req_valid = 2'b10; bus.m_op[1] = DMI_OP_NOP; bus.m_addr[1] = 7'($urandom);
    #1; ex = pick(2'b10);
    tick(); m_last = ex; bus.m_req_valid = '0;
    n_vec++; if ({bus.m_rsp_valid, bus.m_rsp_resp, bus.m_rsp_rdata, bus.dmi_req_valid} !== {NREQ'(1) << ex, DMI_RESP_SUCCESS, 32'h0, 1'b0}) begin n_err++; $display("FAIL nop_rsp got v=%b r=%0d d=%h dv=%b want %b/0/0/0", bus.m_rsp_valid, bus.m_rsp_resp, bus.m_rsp_rdata, bus.dmi_req_valid, NREQ'(1) << ex); end
    tick();
    n_vec++; if ({bus.m_rsp_valid, busy, bus.dmi_req_valid} !== 4'b0000) begin n_err++; $display("FAIL nop_done got v=%b busy=%b dv=%b want 0", bus.m_rsp_valid, busy, bus.dmi_req_valid); end
    bus.m_req_valid = 2'b01; bus.m_op[0] = 2'd3;
    #1; ex = pick(2'b01);
    tick(); m_last = ex; bus.m_req_valid = '0;
    n_vec++; if ({bus.m_rsp_valid, bus.m_rsp_resp, bus.m_rsp_rdata, bus.dmi_req_valid} !== {NREQ'(1) << ex, DMI_RESP_FAILED, 32'h0, 1'b0}) begin n_err++; $display("FAIL rsvd_rsp got v=%b r=%0d d=%h dv=%b want %b/2/0/0", bus.m_rsp_valid, bus.m_rsp_resp, bus.m_rsp_rdata, bus.dmi_req_valid, NREQ'(1) << ex); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int ex;
    bus.m_req_valid = 2'b01; bus.m_op[0] = DMI_OP_WRITE; bus.m_addr[0] = 7'($urandom | 1); bus.m_wdata[0] = $urandom;
    tick(); m_last = 0; bus.m_req_valid = '0;
    bus.dmi_req_ready = 1'b1; tick(); bus.dmi_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if ({bus.dmi_req_valid, bus.m_rsp_valid, bus.m_req_ready, busy, grant_id, timeout_count} !== '0) begin n_err++; $display("FAIL rstw_ctrl got dv=%b v=%b rdy=%b busy=%b gid=%0d cnt=%0d want 0", bus.dmi_req_valid, bus.m_rsp_valid, bus.m_req_ready, busy, grant_id, timeout_count); end
    n_vec++; if ({bus.dmi_addr, bus.dmi_wdata, bus.dmi_op} !== '0) begin n_err++; $display("FAIL rstw_payload got a=%h w=%h op=%0d want 0", bus.dmi_addr, bus.dmi_wdata, bus.dmi_op); end
    m_last = NREQ - 1; m_to = 0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.m_req_valid = 2'b11; bus.m_op[0] = DMI_OP_READ; bus.m_op[1] = DMI_OP_READ;
    #1; ex = pick(2'b11);
    n_vec++; if (bus.m_req_ready !== NREQ'(1) << ex) begin n_err++; $display("FAIL rstw_tie got %b want %b", bus.m_req_ready, NREQ'(1) << ex); end
    bus.m_req_valid = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_nop_reserved();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
